// File: rtl/obu_parser_pkg.sv
// Shared types for the AV1 OBU header parser.
//   obu_hdr_t   decoded header fields (obu_size sized for PARSER_MAX_LEB_BYTES)
//   obu_err_e   header error classification
//   OBU_TYPE_*  AV1 obu_type code points
package obu_parser_pkg;

    localparam int PARSER_DATA_WIDTH    = 32;
    localparam int PARSER_MAX_LEB_BYTES = 8;
    localparam int OBU_SIZE_W           = 7 * PARSER_MAX_LEB_BYTES;

    localparam logic [3:0] OBU_TYPE_SEQUENCE_HEADER       = 4'd1;
    localparam logic [3:0] OBU_TYPE_TEMPORAL_DELIMITER    = 4'd2;
    localparam logic [3:0] OBU_TYPE_FRAME_HEADER          = 4'd3;
    localparam logic [3:0] OBU_TYPE_TILE_GROUP            = 4'd4;
    localparam logic [3:0] OBU_TYPE_METADATA              = 4'd5;
    localparam logic [3:0] OBU_TYPE_FRAME                 = 4'd6;
    localparam logic [3:0] OBU_TYPE_REDUNDANT_FRAME_HEADER = 4'd7;
    localparam logic [3:0] OBU_TYPE_TILE_LIST             = 4'd8;
    localparam logic [3:0] OBU_TYPE_PADDING               = 4'd15;

    typedef struct packed {
        logic [3:0]            obu_type;
        logic                  ext_flag;
        logic                  has_size;
        logic [2:0]            temporal_id;
        logic [1:0]            spatial_id;
        logic [OBU_SIZE_W-1:0] obu_size;
        logic [3:0]            hdr_bytes;
    } obu_hdr_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_FORBIDDEN = 2'd1,
        ERR_LEB_OVF   = 2'd2,
        ERR_SIZE_U32  = 2'd3
    } obu_err_e;

endpackage

// File: rtl/leb128_accum.sv
// leb128 accumulator for obu_size.
//   clk, rst    clock, synchronous active-high reset
//   clear       restart accumulation (new header)
//   en          byte_in is a size byte to fold in this cycle
//   byte_in     current leb128 byte
//   value_next  accumulated value including byte_in (valid when en)
//   last        byte_in terminates the leb128 field (continuation bit clear)
//   ovf         byte_in continues but is already the last permitted byte
//   over_u32    value_next does not fit in 32 bits
module leb128_accum #(
    parameter int MAX_LEB_BYTES = 8,
    parameter int SIZE_W        = 7 * MAX_LEB_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [7:0]        byte_in,
    output logic [SIZE_W-1:0] value_next,
    output logic              last,
    output logic              ovf,
    output logic              over_u32
);

    localparam int IDX_W = (MAX_LEB_BYTES > 1) ? $clog2(MAX_LEB_BYTES) : 1;

    logic [SIZE_W-1:0] value_reg;
    logic [IDX_W-1:0]  idx_reg;

    // Each leb128 byte carries 7 payload bits, little-endian by group.
    assign value_next = value_reg | (SIZE_W'(byte_in[6:0]) << (7 * idx_reg));
    assign last       = ~byte_in[7];
    assign ovf        = byte_in[7] && (idx_reg == IDX_W'(MAX_LEB_BYTES - 1));

    generate
        if (SIZE_W > 32) begin : g_u32
            assign over_u32 = |value_next[SIZE_W-1:32];
        end else begin : g_no_u32
            assign over_u32 = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value_reg <= '0;
            idx_reg   <= '0;
        end else if (en) begin
            value_reg <= value_next;
            idx_reg   <= idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/obu_header_unpacker.sv
// AV1 OBU header parser: obu_header, optional extension, optional leb128 size.
//   clk, rst    clock, synchronous active-high reset
//   data_in     input word, lane 0 in the top byte (stream order)
//   avail       data_in valid this cycle
//   start       begin a header (IDLE only), start_lane = first header byte lane
//   busy        parser not idle
//   done        one-cycle pulse: hdr, error, next_lane, pad, pad_len valid
//   hdr         decoded header fields
//   error       with done: header malformed, err_code gives the reason
//   next_lane   lane of the first payload byte
//   pad/pad_len with done: current word partly used / bits left in it
//   pop         combinational: last lane of the current word consumed this cycle
module obu_header_unpacker
    import obu_parser_pkg::*;
#(
    parameter int DATA_W        = PARSER_DATA_WIDTH,
    parameter int MAX_LEB_BYTES = PARSER_MAX_LEB_BYTES,
    parameter int CHECK_U32     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         avail,
    input  logic                         start,
    input  logic [$clog2(DATA_W/8)-1:0]  start_lane,
    output logic                         busy,
    output logic                         done,
    output obu_hdr_t                     hdr,
    output logic                         error,
    output obu_err_e                     err_code,
    output logic [$clog2(DATA_W/8)-1:0]  next_lane,
    output logic                         pad,
    output logic [$clog2(DATA_W):0]      pad_len,
    output logic                         pop
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int SIZE_W = 7 * MAX_LEB_BYTES;
    localparam int PAD_W  = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_EXT, S_SIZE, S_FIN} state_e;

    state_e            state_reg, state_next;
    logic [LANE_W-1:0] ptr_reg, ptr_next;
    obu_hdr_t          hdr_reg, hdr_next;
    obu_err_e          err_reg, err_next;

    logic [7:0]        lane_bytes [NB];
    logic [7:0]        cur_byte;
    logic              used;
    logic              last_lane;
    logic [LANE_W-1:0] ptr_adv;

    logic [SIZE_W-1:0] acc_value_next;
    logic              acc_last, acc_ovf, acc_over_u32;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_bytes[gi] = data_in[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    assign cur_byte  = lane_bytes[ptr_reg];
    assign used      = avail && (state_reg == S_HDR || state_reg == S_EXT || state_reg == S_SIZE);
    assign last_lane = (ptr_reg == LANE_W'(NB - 1));
    assign ptr_adv   = last_lane ? '0 : ptr_reg + 1'b1;

    leb128_accum #(
        .MAX_LEB_BYTES (MAX_LEB_BYTES),
        .SIZE_W        (SIZE_W)
    ) u_leb128_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg == S_IDLE && start),
        .en         (used && state_reg == S_SIZE),
        .byte_in    (cur_byte),
        .value_next (acc_value_next),
        .last       (acc_last),
        .ovf        (acc_ovf),
        .over_u32   (acc_over_u32)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        hdr_next   = hdr_reg;
        err_next   = err_reg;

        if (used) begin
            ptr_next           = ptr_adv;
            hdr_next.hdr_bytes = hdr_reg.hdr_bytes + 4'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_HDR;
                    ptr_next   = start_lane;
                    hdr_next   = '0;
                    err_next   = ERR_NONE;
                end
            end
            S_HDR: begin
                if (avail) begin
                    hdr_next.obu_type = cur_byte[6:3];
                    hdr_next.ext_flag = cur_byte[2];
                    hdr_next.has_size = cur_byte[1];
                    if (cur_byte[7]) begin
                        err_next   = ERR_FORBIDDEN;
                        state_next = S_FIN;
                    end else if (cur_byte[2]) begin
                        state_next = S_EXT;
                    end else if (cur_byte[1]) begin
                        state_next = S_SIZE;
                    end else begin
                        state_next = S_FIN;
                    end
                end
            end
            S_EXT: begin
                if (avail) begin
                    hdr_next.temporal_id = cur_byte[7:5];
                    hdr_next.spatial_id  = cur_byte[4:3];
                    state_next = hdr_reg.has_size ? S_SIZE : S_FIN;
                end
            end
            S_SIZE: begin
                if (avail) begin
                    hdr_next.obu_size = OBU_SIZE_W'(acc_value_next);
                    // Overflow wins: an unterminated field has no meaningful final value.
                    if (acc_ovf) begin
                        err_next   = ERR_LEB_OVF;
                        state_next = S_FIN;
                    end else if (acc_last) begin
                        state_next = S_FIN;
                        if (CHECK_U32 != 0 && acc_over_u32) begin
                            err_next = ERR_SIZE_U32;
                        end
                    end
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            hdr_reg   <= '0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            hdr_reg   <= hdr_next;
            err_reg   <= err_next;
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_FIN);
    assign hdr       = hdr_reg;
    assign err_code  = err_reg;
    assign error     = done && (err_reg != ERR_NONE);
    assign next_lane = ptr_reg;
    assign pad       = done && (ptr_reg != '0);
    assign pad_len   = done ? PAD_W'((NB - int'(ptr_reg)) * 8) : '0;
    assign pop       = used && last_lane;

endmodule
